ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Arbitrates the single shared 2 KB system RAM between the 6502 core, the VGA renderer and the UART program loader. It replaces the ad-hoc `cpu_ready` logic in the top level with an explicit state machine:
- halts the CPU only on an instruction boundary;
- inserts drain and restore turnaround cycles so the registered RAM read data is always valid for its owner;
- hands the RAM to the display or the loader with a request/grant handshake.

It sits between the three requesters and the `generic_ram` instance.

## Interface
Parameters:
- `ADDR_WIDTH`, 11, RAM address width.
- `DATA_WIDTH`, 8, RAM data width.
- `SYNC_TIMEOUT`, 15, maximum cycles to wait for `cpu_sync` before forcing a halt (range 1..255).

Ports:
- `clk`  in  1  system clock (25 MHz).
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_addr`  in  ADDR_WIDTH  CPU address bus.
- `cpu_wdata`  in  DATA_WIDTH  CPU write data.
- `cpu_we`  in  1  CPU write enable.
- `cpu_sync`  in  1  CPU is fetching an opcode this cycle.
- `cpu_rdy`  out  1  CPU RDY; 0 pauses the core.
- `vga_req`  in  1  level request from the renderer, held for the whole access window.
- `vga_addr`  in  ADDR_WIDTH  renderer read address.
- `vga_gnt`  out  1  renderer owns the RAM.
- `uart_req`  in  1  level request from the loader.
- `uart_addr`  in  ADDR_WIDTH  loader write address.
- `uart_wdata`  in  DATA_WIDTH  loader write data.
- `uart_we`  in  1  loader write strobe.
- `uart_gnt`  out  1  loader owns the RAM.
- `ram_addr`  out  ADDR_WIDTH  to RAM raddr and waddr.
- `ram_wdata`  out  DATA_WIDTH  to RAM din.
- `ram_we`  out  1  to RAM write_en.
- `owner`  out  2  current owner: 00 none, 01 cpu, 10 vga, 11 uart.
- `sync_timeout`  out  1  sticky flag: a halt was forced without `cpu_sync`.

## Operation
States: IDLE, CPU, DRAIN, VGA, UART, RESTORE.

**IDLE** (reset state)
- All grants 0, `cpu_rdy` 0, `ram_we` 0.
- Mux selects `cpu_addr`.
- Next state is always RESTORE.

**CPU**
- `cpu_rdy`=1, `owner`=01.
- Mux selects the CPU; `ram_we`=`cpu_we`.
- If `vga_req|uart_req`:
  - a wait counter increments each cycle.
  - On `cpu_sync`=1, or when the counter reaches `SYNC_TIMEOUT`, go to DRAIN.
  - A timeout also sets `sync_timeout`.
- The counter clears when the state is left or when no request is pending.

**DRAIN**
- `cpu_rdy`=0, mux still selects `cpu_addr`, `ram_we` forced to 0.
- This lets the opcode read issued on the SYNC cycle complete.
- Next state: VGA if `vga_req`, else UART if `uart_req`, else RESTORE.

**VGA**
- `vga_gnt`=1, `owner`=10, mux selects `vga_addr`, `ram_we`=0.
- Stay while `vga_req`=1.
- On release: go to UART if `uart_req`, else RESTORE.

**UART**
- `uart_gnt`=1, `owner`=11.
- Mux selects `uart_addr`/`uart_wdata`; `ram_we`=`uart_we`.
- Stay while `uart_req`=1; there is no preemption by `vga_req`.
- On release: go to VGA if `vga_req`, else RESTORE.

**RESTORE**
- `cpu_rdy`=0, mux selects `cpu_addr`, `ram_we`=0.
- This presents the paused CPU's address for one cycle so `ram_rdata` matches it when RDY rises.
- Next state is always CPU.
- Pending requests are re-evaluated only from CPU, which guarantees the CPU progresses to at least its next SYNC.

Other rules:
- `ram_wdata` always follows the selected requester's data; it is the CPU's data outside VGA/UART.
- `sync_timeout` clears only on reset.

## Timing
- `cpu_rdy`, `vga_gnt`, `uart_gnt` and `owner` are registered, decoded from the state register.
- `ram_addr`, `ram_wdata` and `ram_we` are combinational muxes on the state register plus the requester inputs.
- Reset values (asynchronous on `reset_n`=0):
  - state IDLE; all grants 0; `cpu_rdy` 0; `ram_we` 0; `owner` 00; `sync_timeout` 0; counter 0.
- Reset mid-grant drops every grant immediately; a write in flight is suppressed.
- Halt latency, with a request and `cpu_sync` both high in CPU at cycle n:
  - n: `cpu_rdy`=1 (the fetch proceeds).
  - n+1: DRAIN.
  - n+2: grant=1.
- Simultaneous `vga_req` and `uart_req` at DRAIN: VGA wins.
- Release latency, with the last request low at cycle m in VGA/UART:
  - m+1: RESTORE.
  - m+2: `cpu_rdy`=1.
- A request dropped during DRAIN (none pending) goes to RESTORE; the CPU loses 2 cycles.
- The RAM has 1-cycle read latency: data for the address presented at cycle k is valid at k+1. Every owner change therefore passes through a cycle that still presents the incoming or outgoing CPU address.

## Test plan
- Reset release, no requests → IDLE at cycle 0, RESTORE at 1, `cpu_rdy`=1 from cycle 2; `owner`=01.
- `vga_req`=1 at n, `cpu_sync`=1 at n+3 → `cpu_rdy` falls at n+4, `vga_gnt`=1 at n+5, `ram_addr`=`vga_addr`, `ram_we`=0 even with `cpu_we`=1.
- Both requests together → VGA served first. On `vga_req` drop, UART is granted next cycle with no RESTORE. UART writes 0xA5 to 0x123 → `ram_we`=1, `ram_addr`=0x123.
- Request held, `cpu_sync` never asserted → DRAIN after 15 waiting cycles, `sync_timeout`=1 and stays 1 after the grant ends.
- Release in VGA → RESTORE with `ram_addr`=`cpu_addr` and `cpu_rdy`=0, then `cpu_rdy`=1; the bench checks the opcode read matches RAM at the held address.
- `reset_n` low during UART grant with `uart_we`=1 → `uart_gnt`, `ram_we`, `cpu_rdy` all 0 within the same cycle; state IDLE.

Source files
------------

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// ram_arbiter : shared-RAM arbiter for the 6502 core, VGA renderer and UART loader
// Revision    : 1.0
// ============================================================================
module ram_arbiter #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 8,
  parameter int SYNC_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_we,
  input  logic                  cpu_sync,
  output logic                  cpu_rdy,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic                  vga_gnt,
  input  logic                  uart_req,
  input  logic [ADDR_WIDTH-1:0] uart_addr,
  input  logic [DATA_WIDTH-1:0] uart_wdata,
  input  logic                  uart_we,
  output logic                  uart_gnt,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  output logic [1:0]            owner,
  output logic                  sync_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CPU     = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_VGA     = 3'd3,
    ST_UART    = 3'd4,
    ST_RESTORE = 3'd5
  } state_t;

  // The wait counter holds the number of completed waiting cycles, so the
  // halt is taken on the cycle in which it would reach SYNC_TIMEOUT.
  localparam logic [7:0] C_WAIT_LAST = 8'(SYNC_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait;
  logic       w_req;
  logic       w_timeout_hit;
  logic       w_force;
  logic [1:0] w_owner_next;

  assign w_req         = vga_req | uart_req;
  assign w_timeout_hit = (r_wait == C_WAIT_LAST);
  assign w_force       = (r_state == ST_CPU) && w_req && !cpu_sync && w_timeout_hit;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    w_next = ST_RESTORE;
      ST_CPU: begin
        if (w_req && (cpu_sync || w_timeout_hit)) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (vga_req)       w_next = ST_VGA;
        else if (uart_req) w_next = ST_UART;
        else               w_next = ST_RESTORE;
      end
      ST_VGA: begin
        if (!vga_req) w_next = uart_req ? ST_UART : ST_RESTORE;
      end
      ST_UART: begin
        // The loader is never preempted; VGA waits for the release.
        if (!uart_req) w_next = vga_req ? ST_VGA : ST_RESTORE;
      end
      ST_RESTORE: w_next = ST_CPU;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_owner_next = 2'b00;
    case (w_next)
      ST_CPU:  w_owner_next = 2'b01;
      ST_VGA:  w_owner_next = 2'b10;
      ST_UART: w_owner_next = 2'b11;
      default: w_owner_next = 2'b00;
    endcase
  end

  // Grants are registered from the next state so they always match r_state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_wait       <= 8'd0;
      cpu_rdy      <= 1'b0;
      vga_gnt      <= 1'b0;
      uart_gnt     <= 1'b0;
      owner        <= 2'b00;
      sync_timeout <= 1'b0;
    end else begin
      r_state  <= w_next;
      cpu_rdy  <= (w_next == ST_CPU);
      vga_gnt  <= (w_next == ST_VGA);
      uart_gnt <= (w_next == ST_UART);
      owner    <= w_owner_next;
      if ((r_state == ST_CPU) && w_req && (w_next == ST_CPU)) r_wait <= r_wait + 8'd1;
      else                                                     r_wait <= 8'd0;
      if (w_force) sync_timeout <= 1'b1;
    end
  end

  // Outside VGA/UART the CPU address stays on the bus so read data tracks it.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = 1'b0;
    case (r_state)
      ST_CPU:  ram_we = cpu_we;
      ST_VGA:  ram_addr = vga_addr;
      ST_UART: begin
        ram_addr  = uart_addr;
        ram_wdata = uart_wdata;
        ram_we    = uart_we;
      end
      default: ram_we = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ram_arbiter : vector table, directed corner sequences and random run
// Revision       : 1.0
// ============================================================================
module tb_ram_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int TO = 15;
  localparam logic [AW-1:0] CA = 11'h055;
  localparam logic [AW-1:0] VA = 11'h2AA;
  localparam logic [AW-1:0] UA = 11'h123;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [AW-1:0] cpu_addr, vga_addr, uart_addr, ram_addr;
  logic [DW-1:0] cpu_wdata, uart_wdata, ram_wdata;
  logic          cpu_we, cpu_sync, cpu_rdy, vga_req, vga_gnt;
  logic          uart_req, uart_we, uart_gnt, ram_we, sync_timeout;
  logic [1:0]    owner;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_sync(cpu_sync),
    .cpu_rdy(cpu_rdy),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .uart_req(uart_req), .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_we(uart_we),
    .uart_gnt(uart_gnt),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .owner(owner), .sync_timeout(sync_timeout)
  );

  function automatic logic [7:0] pattern(input int a);
    return 8'((a * 7 + 3) ^ (a >> 3));
  endfunction

  // Behavioural RAM with one-cycle read latency driven by the arbiter.
  logic [7:0] mem [2048];
  logic [7:0] ram_rdata;
  bit         mem_ready;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2048; i++) mem[i] <= pattern(i);
      mem_ready <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: who holds the RAM, plus which turnaround is in progress
  // while nobody does (0 after reset, 1 halting the CPU, 2 handing back).
  typedef struct packed {
    logic          rdy, vg, ug;
    logic [1:0]    own;
    logic          we;
    logic [AW-1:0] addr;
    logic          flag;
  } outs_t;

  int         m_own;
  int         m_turn;
  int         m_wait;
  bit         m_flag;
  logic [7:0] gold [2048];

  function automatic void model_reset();
    m_own  = 0;
    m_turn = 0;
    m_wait = 0;
    m_flag = 1'b0;
  endfunction

  function automatic outs_t model_out();
    outs_t o;
    o.rdy  = (m_own == 1);
    o.vg   = (m_own == 2);
    o.ug   = (m_own == 3);
    o.own  = 2'(m_own);
    o.we   = (m_own == 1) ? cpu_we : (m_own == 3) ? uart_we : 1'b0;
    o.addr = (m_own == 2) ? vga_addr : (m_own == 3) ? uart_addr : cpu_addr;
    o.flag = m_flag;
    return o;
  endfunction

  function automatic void hand_back();
    m_own  = 0;
    m_turn = 2;
  endfunction

  function automatic void model_advance();
    outs_t e;
    e = model_out();
    if (e.we) gold[e.addr] = (m_own == 3) ? uart_wdata : cpu_wdata;
    case (m_own)
      0: begin
        if (m_turn == 0)      m_turn = 2;
        else if (m_turn == 2) m_own = 1;
        else if (vga_req)     m_own = 2;
        else if (uart_req)    m_own = 3;
        else                  m_turn = 2;
      end
      1: begin
        if (vga_req || uart_req) begin
          m_wait++;
          if (cpu_sync || m_wait >= TO) begin
            if (!cpu_sync) m_flag = 1'b1;
            m_own  = 0;
            m_turn = 1;
            m_wait = 0;
          end
        end else begin
          m_wait = 0;
        end
      end
      2: if (!vga_req) begin
        if (uart_req) m_own = 3;
        else          hand_back();
      end
      default: if (!uart_req) begin
        if (vga_req) m_own = 2;
        else         hand_back();
      end
    endcase
  endfunction

  typedef struct packed {
    logic        vr, ur, sy, cw, uw;
    logic [16:0] exp;
  } vec_t;

  function automatic vec_t v(input bit vr, ur, sy, cw, uw, input bit rdy, vg, ug,
                             input bit [1:0] ow, input bit we, input bit [AW-1:0] ad);
    vec_t r;
    r.vr = vr; r.ur = ur; r.sy = sy; r.cw = cw; r.uw = uw;
    r.exp = {rdy, vg, ug, ow, we, ad};
    return r;
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step(input bit tab_en, input vec_t tv, input int row);
    outs_t         e, a;
    logic [DW-1:0] ew;
    @(negedge clk);
    e  = model_out();
    a  = {cpu_rdy, vga_gnt, uart_gnt, owner, ram_we, ram_addr, sync_timeout};
    chk("model outputs", 64'(a), 64'(e));
    if (m_own != 2) begin
      ew = (m_own == 3) ? uart_wdata : cpu_wdata;
      chk("ram_wdata", 64'(ram_wdata), 64'(ew));
    end
    if (tab_en) chk($sformatf("table row %0d", row), 64'(a[17:1]), 64'(tv.exp));
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_advance();
    #1;
  endtask

  vec_t tab [27];
  vec_t blank;

  initial begin
    blank = '0;
    for (int i = 0; i < 2048; i++) gold[i] = pattern(i);
    model_reset();
    reset_n = 1'b0;
    cpu_addr = CA; vga_addr = VA; uart_addr = UA;
    cpu_wdata = 8'h3C; uart_wdata = 8'hA5;
    cpu_we = 0; cpu_sync = 0; vga_req = 0; uart_req = 0; uart_we = 0;

    //          vr ur sy cw uw  rdy vg ug own we addr
    tab[0]  = v(0, 0, 0, 0, 0,  0,  0, 0, 0, 0, CA);
    tab[1]  = v(0, 0, 0, 1, 0,  0,  0, 0, 0, 0, CA);
    tab[2]  = v(0, 0, 0, 1, 0,  1,  0, 0, 1, 1, CA);
    tab[3]  = v(1, 0, 0, 0, 0,  1,  0, 0, 1, 0, CA);
    tab[4]  = v(1, 0, 0, 0, 0,  1,  0, 0, 1, 0, CA);
    tab[5]  = v(1, 0, 0, 0, 0,  1,  0, 0, 1, 0, CA);
    tab[6]  = v(1, 0, 1, 0, 0,  1,  0, 0, 1, 0, CA);
    tab[7]  = v(1, 0, 0, 1, 0,  0,  0, 0, 0, 0, CA);
    tab[8]  = v(1, 0, 0, 1, 0,  0,  1, 0, 2, 0, VA);
    tab[9]  = v(1, 1, 0, 0, 0,  0,  1, 0, 2, 0, VA);
    tab[10] = v(0, 1, 0, 0, 1,  0,  1, 0, 2, 0, VA);
    tab[11] = v(0, 1, 0, 0, 1,  0,  0, 1, 3, 1, UA);
    tab[12] = v(0, 0, 0, 0, 0,  0,  0, 1, 3, 0, UA);
    tab[13] = v(0, 0, 0, 0, 0,  0,  0, 0, 0, 0, CA);
    tab[14] = v(0, 0, 0, 0, 0,  1,  0, 0, 1, 0, CA);
    tab[15] = v(1, 1, 1, 0, 0,  1,  0, 0, 1, 0, CA);
    tab[16] = v(1, 1, 0, 0, 0,  0,  0, 0, 0, 0, CA);
    tab[17] = v(1, 1, 0, 0, 0,  0,  1, 0, 2, 0, VA);
    tab[18] = v(0, 1, 0, 0, 1,  0,  1, 0, 2, 0, VA);
    tab[19] = v(0, 1, 0, 0, 1,  0,  0, 1, 3, 1, UA);
    tab[20] = v(0, 0, 0, 0, 0,  0,  0, 1, 3, 0, UA);
    tab[21] = v(0, 0, 0, 0, 0,  0,  0, 0, 0, 0, CA);
    tab[22] = v(0, 0, 0, 0, 0,  1,  0, 0, 1, 0, CA);
    tab[23] = v(1, 0, 1, 0, 0,  1,  0, 0, 1, 0, CA);
    tab[24] = v(0, 0, 0, 0, 0,  0,  0, 0, 0, 0, CA);
    tab[25] = v(0, 0, 0, 0, 0,  0,  0, 0, 0, 0, CA);
    tab[26] = v(0, 0, 0, 0, 0,  1,  0, 0, 1, 0, CA);

    step(0, blank, 0);
    step(0, blank, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 27; i++) begin
      vga_req = tab[i].vr; uart_req = tab[i].ur; cpu_sync = tab[i].sy;
      cpu_we  = tab[i].cw; uart_we  = tab[i].uw;
      step(1, tab[i], i);
    end

    // Request held without SYNC: the halt is forced after TO waiting cycles.
    vga_req = 1; cpu_sync = 0; cpu_we = 0; uart_req = 0; uart_we = 0;
    for (int i = 0; i < TO - 1; i++) step(0, blank, 0);
    chk("rdy on last waiting cycle", 64'(cpu_rdy), 64'(1));
    chk("flag before timeout", 64'(sync_timeout), 64'(0));
    step(0, blank, 0);
    chk("rdy low after timeout", 64'(cpu_rdy), 64'(0));
    chk("sync_timeout set", 64'(sync_timeout), 64'(1));
    cpu_we = 1;
    step(0, blank, 0);
    chk("vga_gnt after drain", 64'(vga_gnt), 64'(1));
    chk("ram_we blocked in vga", 64'(ram_we), 64'(0));
    step(0, blank, 0);
    vga_req = 0; cpu_we = 0; cpu_addr = 11'h3C1;
    step(0, blank, 0);
    chk("restore rdy", 64'(cpu_rdy), 64'(0));
    chk("restore addr", 64'(ram_addr), 64'(11'h3C1));
    step(0, blank, 0);
    chk("rdy after restore", 64'(cpu_rdy), 64'(1));
    chk("opcode read data", 64'(ram_rdata), 64'(gold[11'h3C1]));
    chk("sync_timeout sticky", 64'(sync_timeout), 64'(1));

    // Reset while the loader is writing.
    uart_req = 1; cpu_sync = 1; uart_we = 1; uart_addr = UA; uart_wdata = 8'hA5;
    step(0, blank, 0);
    cpu_sync = 0;
    step(0, blank, 0);
    chk("uart_gnt before reset", 64'(uart_gnt), 64'(1));
    chk("uart write before reset", 64'({ram_we, ram_addr}), 64'({1'b1, UA}));
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("uart_gnt in reset", 64'(uart_gnt), 64'(0));
    chk("ram_we in reset", 64'(ram_we), 64'(0));
    chk("cpu_rdy in reset", 64'(cpu_rdy), 64'(0));
    chk("owner in reset", 64'({owner, sync_timeout}), 64'(0));
    @(posedge clk);
    #1;
    uart_req = 0; uart_we = 0;
    step(0, blank, 0);
    reset_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) vga_req = ~vga_req;
      if ($urandom_range(0, 9) == 0) uart_req = ~uart_req;
      cpu_sync   = (c < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 39) == 0);
      cpu_we     = ($urandom_range(0, 3) == 0);
      uart_we    = 1'($urandom_range(0, 1));
      cpu_addr   = 11'($urandom);
      vga_addr   = 11'($urandom);
      uart_addr  = 11'($urandom);
      cpu_wdata  = 8'($urandom);
      uart_wdata = 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        model_reset();
      end else begin
        reset_n = 1'b1;
      end
      step(0, blank, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
